// File: rtl/inst_queue_reg.sv
// ============================================================================
// Module   : inst_queue_reg
// Brief    : Fetch-to-decode instruction buffer: DEPTH-entry FIFO feeding a
//            registered decode stage with pre-extracted instruction fields.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_queue_reg #(
    parameter int                INST_W = 16,
    parameter int                IMM_W  = 8,
    parameter int                ADDR_W = 4,
    parameter int                RA_LSB = 0,
    parameter int                RB_LSB = 8,
    parameter int                DEPTH  = 2,
    parameter logic [INST_W-1:0] NOP    = 'h0020
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         stall_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [INST_W-1:0]            inst_i,
    output logic                         out_valid_o,
    output logic [INST_W-1:0]            inst_o,
    output logic [IMM_W-1:0]             imm_o,
    output logic [INST_W-1:0]            displacement_o,
    output logic [ADDR_W-1:0]            addr_a_o,
    output logic [ADDR_W-1:0]            addr_b_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int                  c_cnt_w    = $clog2(DEPTH + 1);
    localparam int                  c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0]  c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0]  c_depth    = c_cnt_w'(DEPTH);

    logic [INST_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               r_valid;
    logic [INST_W-1:0]  r_inst;
    logic [IMM_W-1:0]   r_imm;
    logic [INST_W-1:0]  r_disp;
    logic [ADDR_W-1:0]  r_addr_a;
    logic [ADDR_W-1:0]  r_addr_b;

    logic               w_push;
    logic               w_advance;
    logic               w_empty;
    logic               w_pop;
    logic               w_bypass;
    logic               w_fifo_wr;
    logic               w_load;
    logic               w_next_valid;
    logic [INST_W-1:0]  w_next_inst;
    logic [INST_W-1:0]  w_next_disp;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_last_ptr) ? '0 : ptr + 1'b1;
    endfunction

    // Ready is derived from occupancy alone so fetch never sees a combinational
    // path from decode stall/flush.
    assign in_ready_o = (r_count < c_depth);
    assign w_push     = in_valid_i & in_ready_o & ~flush_i;
    assign w_advance  = ~flush_i & ~stall_i;
    assign w_empty    = (r_count == '0);
    assign w_pop      = w_advance & ~w_empty;
    assign w_bypass   = w_advance & w_empty & w_push;
    assign w_fifo_wr  = w_push & ~w_bypass;
    assign w_load     = flush_i | ~stall_i;

    always_comb begin
        w_next_inst  = NOP;
        w_next_valid = 1'b0;
        if (w_pop) begin
            w_next_inst  = r_mem[r_rd_ptr];
            w_next_valid = 1'b1;
        end else if (w_bypass) begin
            w_next_inst  = inst_i;
            w_next_valid = 1'b1;
        end
    end

    generate
        if (INST_W > IMM_W) begin : g_disp_ext
            assign w_next_disp = {{(INST_W - IMM_W){w_next_inst[IMM_W-1]}},
                                  w_next_inst[IMM_W-1:0]};
        end else begin : g_disp_same
            assign w_next_disp = w_next_inst;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (w_fifo_wr) begin
            r_mem[r_wr_ptr] <= inst_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + c_cnt_w'(w_fifo_wr) - c_cnt_w'(w_pop);
        end
    end

    // All decode fields are captured from the same word as inst_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid  <= 1'b0;
            r_inst   <= '0;
            r_imm    <= '0;
            r_disp   <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
        end else if (w_load) begin
            r_valid  <= w_next_valid;
            r_inst   <= w_next_inst;
            r_imm    <= w_next_inst[IMM_W-1:0];
            r_disp   <= w_next_disp;
            r_addr_a <= w_next_inst[RA_LSB +: ADDR_W];
            r_addr_b <= w_next_inst[RB_LSB +: ADDR_W];
        end
    end

    assign out_valid_o    = r_valid;
    assign inst_o         = r_inst;
    assign imm_o          = r_imm;
    assign displacement_o = r_disp;
    assign addr_a_o       = r_addr_a;
    assign addr_b_o       = r_addr_b;
    assign count_o        = r_count;

endmodule

`default_nettype wire

// File: tb/tb_inst_queue_reg.sv
// ============================================================================
// Module   : tb_inst_queue_reg
// Brief    : Self-checking bench for inst_queue_reg at DEPTH=2 and DEPTH=3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_queue_reg;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        flush    = 1'b0;
    logic        stall    = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] inst_in  = 16'h0;

    logic        in_ready_a  [2];
    logic        out_valid_a [2];
    logic [15:0] inst_a      [2];
    logic [7:0]  imm_a       [2];
    logic [15:0] disp_a      [2];
    logic [3:0]  aa_a        [2];
    logic [3:0]  ab_a        [2];
    logic [1:0]  cnt_a       [2];

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D = g + 2;

        inst_queue_reg #(.DEPTH(D)) dut (
            .clk_i          (clk),
            .rst_ni         (rst_n),
            .flush_i        (flush),
            .stall_i        (stall),
            .in_valid_i     (in_valid),
            .in_ready_o     (in_ready_a[g]),
            .inst_i         (inst_in),
            .out_valid_o    (out_valid_a[g]),
            .inst_o         (inst_a[g]),
            .imm_o          (imm_a[g]),
            .displacement_o (disp_a[g]),
            .addr_a_o       (aa_a[g]),
            .addr_b_o       (ab_a[g]),
            .count_o        (cnt_a[g])
        );

        // Reference: a queue of pending words plus the word currently shown.
        logic [15:0] mq [$];
        logic [15:0] m_inst;
        bit          m_valid;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mq.delete();
                m_inst  = 16'h0;
                m_valid = 1'b0;
            end else begin
                bit push;
                push = in_valid && (mq.size() < D) && !flush;
                if (flush) begin
                    mq.delete();
                    m_inst  = 16'h0020;
                    m_valid = 1'b0;
                end else if (stall) begin
                    if (push) mq.push_back(inst_in);
                end else if (mq.size() > 0) begin
                    m_inst  = mq.pop_front();
                    m_valid = 1'b1;
                    if (push) mq.push_back(inst_in);
                end else if (push) begin
                    m_inst  = inst_in;
                    m_valid = 1'b1;
                end else begin
                    m_inst  = 16'h0020;
                    m_valid = 1'b0;
                end
            end
        end

        always @(negedge clk) begin
            if (cmp_en) begin
                logic [15:0] e_disp;
                e_disp = m_inst[7] ? (16'hFF00 | {8'h0, m_inst[7:0]}) : (m_inst & 16'h00FF);
                chk($sformatf("d%0d_inst", D),  {16'h0, inst_a[g]},  {16'h0, m_inst});
                chk($sformatf("d%0d_valid", D), {31'h0, out_valid_a[g]}, {31'h0, m_valid});
                chk($sformatf("d%0d_imm", D),   {24'h0, imm_a[g]},   {16'h0, m_inst & 16'h00FF});
                chk($sformatf("d%0d_disp", D),  {16'h0, disp_a[g]},  {16'h0, e_disp});
                chk($sformatf("d%0d_addr_a", D), {28'h0, aa_a[g]},   {28'h0, m_inst[3:0]});
                chk($sformatf("d%0d_addr_b", D), {28'h0, ab_a[g]},   {28'h0, m_inst[11:8]});
                chk($sformatf("d%0d_count", D), {30'h0, cnt_a[g]},   mq.size());
                chk($sformatf("d%0d_ready", D), {31'h0, in_ready_a[g]}, {31'h0, (mq.size() < D)});
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_inst%0d", tag, k),  {16'h0, inst_a[k]}, 32'h0);
            chk($sformatf("%s_imm%0d", tag, k),   {24'h0, imm_a[k]}, 32'h0);
            chk($sformatf("%s_disp%0d", tag, k),  {16'h0, disp_a[k]}, 32'h0);
            chk($sformatf("%s_valid%0d", tag, k), {31'h0, out_valid_a[k]}, 32'h0);
            chk($sformatf("%s_count%0d", tag, k), {30'h0, cnt_a[k]}, 32'h0);
            chk($sformatf("%s_ready%0d", tag, k), {31'h0, in_ready_a[k]}, 32'h1);
        end
    endtask

    initial begin
        logic [15:0] word;
        bit          rdy;

        // Reset and idle
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        step();
        chk("idle_inst", {16'h0, inst_a[0]}, 32'h0020);
        chk("idle_imm",  {24'h0, imm_a[0]},  32'h20);
        chk("idle_valid", {31'h0, out_valid_a[0]}, 32'h0);

        // Single word bypass
        in_valid = 1'b1; inst_in = 16'h35F2;
        step();
        in_valid = 1'b0;
        chk("byp_inst",  {16'h0, inst_a[0]}, 32'h35F2);
        chk("byp_imm",   {24'h0, imm_a[0]},  32'hF2);
        chk("byp_disp",  {16'h0, disp_a[0]}, 32'hFFF2);
        chk("byp_addr_a", {28'h0, aa_a[0]},  32'h2);
        chk("byp_addr_b", {28'h0, ab_a[0]},  32'h5);
        chk("byp_valid", {31'h0, out_valid_a[0]}, 32'h1);
        chk("byp_count", {30'h0, cnt_a[0]},  32'h0);

        // Stall while pushing three words into a two-entry FIFO
        stall = 1'b1; in_valid = 1'b1; inst_in = 16'h1101;
        step();
        inst_in = 16'h1202;
        step();
        inst_in = 16'h1303;
        step();
        chk("full_count", {30'h0, cnt_a[0]}, 32'h2);
        chk("full_ready", {31'h0, in_ready_a[0]}, 32'h0);
        step();
        chk("stall_hold", {16'h0, inst_a[0]}, 32'h35F2);
        stall = 1'b0;
        step();
        chk("drain1_inst",  {16'h0, inst_a[0]}, 32'h1101);
        chk("drain1_count", {30'h0, cnt_a[0]},  32'h1);
        step();
        in_valid = 1'b0;
        chk("drain2_inst",  {16'h0, inst_a[0]}, 32'h1202);
        chk("drain2_count", {30'h0, cnt_a[0]},  32'h1);
        step();
        chk("drain3_inst",  {16'h0, inst_a[0]}, 32'h1303);
        chk("drain3_count", {30'h0, cnt_a[0]},  32'h0);
        step();
        chk("bubble_valid", {31'h0, out_valid_a[0]}, 32'h0);

        // Flush overrides stall and drops the offered word
        stall = 1'b1; in_valid = 1'b1; inst_in = 16'hA001;
        step();
        inst_in = 16'hA002;
        step();
        flush = 1'b1; inst_in = 16'h7777;
        step();
        chk("flush_inst",  {16'h0, inst_a[0]}, 32'h0020);
        chk("flush_valid", {31'h0, out_valid_a[0]}, 32'h0);
        chk("flush_count", {30'h0, cnt_a[0]}, 32'h0);
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        step();
        chk("post_flush_inst",  {16'h0, inst_a[0]}, 32'h0020);
        chk("post_flush_valid", {31'h0, out_valid_a[0]}, 32'h0);

        // Randomised streaming with a fetch that holds a word until accepted
        word = 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #3 rst_n = 1'b0;
                #1 chk_reset_outputs("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end
            rdy      = in_ready_a[1];
            stall    = (i < 200) ? ((i % 2) != 0) : (($urandom % 3) == 0);
            flush    = (($urandom % 20) == 0);
            in_valid = (($urandom % 4) != 0);
            inst_in  = word;
            step();
            if ((in_valid && rdy) || flush) word = 16'($urandom);
        end

        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        step();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_queue_reg.md
Name: inst_queue_reg

Overview:
Parametrised fetch-to-decode instruction buffer. Successor to the single-stage instruction register. Adds a DEPTH-entry FIFO with a valid/ready handshake on the fetch side, a decode-side stall, and a flush that squashes queued work and injects a NOP. Its output register drives decode with the instruction word and pre-extracted fields: immediate, sign-extended displacement, and the two register addresses.

Parameters:
INST_W, 16, instruction word width
IMM_W, 8, immediate/displacement field width, taken from word[IMM_W-1:0]
ADDR_W, 4, register address width
RA_LSB, 0, LSB of addr_a field in the word
RB_LSB, 8, LSB of addr_b field in the word
DEPTH, 2, FIFO entries (>=1)
NOP, 16'h0020, word injected on flush

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  jump or branch taken; squash and inject NOP
stall_i  in  1  decode stall; hold output register
in_valid_i  in  1  fetch word valid
in_ready_o  out  1  FIFO can accept a word
inst_i  in  INST_W  fetched instruction
out_valid_o  out  1  inst_o holds a real (non-bubble) instruction
inst_o  out  INST_W  registered instruction to decode
imm_o  out  IMM_W  inst_o[IMM_W-1:0]
displacement_o  out  INST_W  inst_o[IMM_W-1:0] sign-extended to INST_W
addr_a_o  out  ADDR_W  inst_o[RA_LSB+:ADDR_W]
addr_b_o  out  ADDR_W  inst_o[RB_LSB+:ADDR_W]
count_o  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (rst_ni=0, asynchronous): inst_o, imm_o, displacement_o, addr_a_o, addr_b_o = 0; out_valid_o=0; count_o=0; FIFO pointers = 0. Outputs are zero after reset, not NOP.
- in_ready_o = (count_o < DEPTH). It depends only on registered state and never combinationally on stall_i, flush_i, or the pop.
- push = in_valid_i & in_ready_o & ~flush_i. A word offered during flush is dropped and fetch must not retry it.
- Each clock edge, priority is flush > stall > advance:
  - flush_i=1: output register loads NOP; out_valid_o=0; FIFO cleared (count 0, pointers reset). This applies even when stall_i=1.
  - stall_i=1, no flush: output register and all fields hold. A push still writes the FIFO if not full.
  - Advance, FIFO non-empty: output loads the FIFO head; pop; out_valid_o=1. A simultaneous push appends at the tail, so count is unchanged.
  - Advance, FIFO empty and push: bypass. inst_i loads directly into the output register; out_valid_o=1; count stays 0.
  - Advance, nothing available: output loads NOP; out_valid_o=0 (bubble).
- Latency: inst_i to inst_o is 1 cycle when the FIFO is empty and there is no stall. Otherwise the word waits behind older entries, strictly in order.
- All fields are registered and decoded from the same word loaded into inst_o in the same edge. For NOP=0x0020: imm_o=0x20, displacement_o=0x0020, addr_a_o=0x0, addr_b_o=0x0.
- Full with a pop in the same cycle: in_ready_o is still 0 that cycle; no push occurs.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- Reset asserted mid-operation: all state returns to reset values immediately; queued words are lost.

Test Plan:
- Reset then idle, no in_valid -> all outputs 0 after reset; after first edge inst_o=0x0020, imm_o=0x20, out_valid_o=0.
- Single word 0x35F2, no stall -> next cycle inst_o=0x35F2, imm_o=0xF2, displacement_o=0xFFF2, addr_a_o=0x2, addr_b_o=0x5, out_valid_o=1, count_o=0.
- stall_i=1 for 4 cycles while pushing 0x1101, 0x1202, 0x1303 -> first two accepted, count_o=2, in_ready_o=0, third held off. Release stall -> inst_o shows 0x1101, 0x1202, 0x1303 in order with no loss or duplicates.
- Two words queued, flush_i=1 with stall_i=1 and in_valid_i=1 (0x7777) -> next cycle inst_o=0x0020, out_valid_o=0, count_o=0; 0x7777 never appears.
- DEPTH=3 continuous streaming with stall toggling every other cycle -> output sequence equals input sequence; count_o never exceeds 3; pointer wrap exercised.
- Assert rst_ni low mid-stream between clock edges -> outputs go to 0 immediately without waiting for a clock edge; after release the FIFO is empty and in_ready_o=1.
